// File: rtl/arith_accum.sv
// Block accumulator: sums in_prod and tracks max of in_sum over COUNT-beat blocks
// (or shorter blocks closed by in_last), presenting one registered result per block.
module arith_accum #(
  parameter int WIDTH     = 8,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_sum,
  input  logic [WIDTH-1:0]             in_prod,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_acc,
  output logic [WIDTH-1:0]             out_max,
  output logic [$clog2(COUNT+1)-1:0]   out_beats
);

  localparam int CNT_W   = $clog2(COUNT);
  localparam int BEATS_W = $clog2(COUNT+1);

  logic [ACC_WIDTH-1:0] acc_q, acc_d, out_acc_q, out_acc_d;
  logic [WIDTH-1:0]     max_q, max_d, out_max_q, out_max_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BEATS_W-1:0]   out_beats_q, out_beats_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept, closing;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]     max_next;

  // Ready only depends on reset and the output slot, so the result register
  // can be refilled in the same cycle it is drained.
  assign in_ready = rst & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign closing  = accept & ((cnt_q == CNT_W'(COUNT-1)) | in_last);
  assign acc_next = acc_q + ACC_WIDTH'(in_prod);
  assign max_next = (in_sum > max_q) ? in_sum : max_q;

  always_comb begin
    acc_d       = acc_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    out_acc_d   = out_acc_q;
    out_max_d   = out_max_q;
    out_beats_d = out_beats_q;
    out_valid_d = out_valid_q;
    if (closing) begin
      out_acc_d   = acc_next;
      out_max_d   = max_next;
      out_beats_d = BEATS_W'(cnt_q) + BEATS_W'(1);
      out_valid_d = 1'b1;
      acc_d       = '0;
      max_d       = '0;
      cnt_d       = '0;
    end else begin
      if (accept) begin
        acc_d = acc_next;
        max_d = max_next;
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q       <= '0;
      max_q       <= '0;
      cnt_q       <= '0;
      out_acc_q   <= '0;
      out_max_q   <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      out_acc_q   <= out_acc_d;
      out_max_q   <= out_max_d;
      out_beats_q <= out_beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_max   = out_max_q;
  assign out_beats = out_beats_q;

endmodule

// File: tb/tb_arith_accum.sv
// Directed plus randomized bench for arith_accum against a queue-based block model.
module tb_arith_accum;
  localparam int WIDTH     = 8;
  localparam int COUNT     = 4;
  localparam int ACC_WIDTH = 2*WIDTH + $clog2(COUNT);
  localparam int BW        = $clog2(COUNT+1);

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in_sum = '0, in_prod = '0;
  logic in_ready, out_valid;
  logic [ACC_WIDTH-1:0] out_acc;
  logic [WIDTH-1:0] out_max;
  logic [BW-1:0] out_beats;

  arith_accum #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_max(out_max), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int q_prod[$], q_sum[$];
  bit e_valid = 0;
  int e_acc = 0, e_max = 0, e_beats = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    bit exp_rdy, acc_ok, close;
    @(negedge clk);
    exp_rdy = rst && (!e_valid || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    acc_ok = in_valid && exp_rdy;
    if (!rst) begin
      q_prod.delete(); q_sum.delete();
      e_valid = 0; e_acc = 0; e_max = 0; e_beats = 0;
    end else begin
      if (acc_ok) begin
        q_prod.push_back(int'(in_prod));
        q_sum.push_back(int'(in_sum));
      end
      close = acc_ok && (in_last || q_prod.size() == COUNT);
      if (close) begin
        e_acc = 0; e_max = 0;
        foreach (q_prod[i]) begin
          e_acc += q_prod[i];
          if (q_sum[i] > e_max) e_max = q_sum[i];
        end
        e_beats = q_prod.size();
        e_valid = 1;
        q_prod.delete(); q_sum.delete();
      end else if (e_valid && out_ready) begin
        e_valid = 0;
      end
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, e_valid);
    chk("out_acc",   out_acc,   e_acc);
    chk("out_max",   out_max,   e_max);
    chk("out_beats", out_beats, e_beats);
  endtask

  task automatic drv(input bit v, input int p, input int s, input bit l, input bit ordy, input bit r);
    in_valid = v; in_prod = WIDTH'(p); in_sum = WIDTH'(s); in_last = l; out_ready = ordy; rst = r;
    step();
  endtask

  initial begin
    // reset held two cycles with traffic offered
    drv(1, 3, 3, 0, 1, 0);
    drv(1, 3, 3, 1, 1, 0);
    chk("rst_acc", out_acc, 0);
    // first cycle out of reset accepts; basic block
    drv(1, 10, 5, 0, 1, 1);
    drv(1, 20, 9, 0, 1, 1);
    drv(1, 30, 3, 0, 1, 1);
    drv(1, 40, 7, 0, 1, 1);
    chk("blk1_acc", out_acc, 100); chk("blk1_max", out_max, 9); chk("blk1_beats", out_beats, 4);
    // back-to-back full-scale block, no wrap
    for (int i = 0; i < 4; i++) drv(1, 255, 255, 0, 1, 1);
    chk("full_acc", out_acc, 1020); chk("full_max", out_max, 255); chk("full_valid", out_valid, 1);
    // early close via in_last, then full block
    drv(1, 7, 1, 0, 1, 1);
    drv(1, 8, 2, 1, 1, 1);
    chk("last_acc", out_acc, 15); chk("last_beats", out_beats, 2);
    for (int i = 0; i < 4; i++) drv(1, 1, 0, 0, 1, 1);
    chk("after_last_acc", out_acc, 4); chk("after_last_beats", out_beats, 4);
    // in_last on first beat
    drv(1, 6, 6, 1, 1, 1);
    chk("single_beats", out_beats, 1);
    // backpressure stall
    drv(1, 10, 5, 0, 1, 1);
    drv(1, 20, 9, 0, 1, 1);
    drv(1, 30, 3, 0, 1, 1);
    drv(1, 40, 7, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drv(1, 99, 99, 1, 0, 1);
      chk("stall_acc", out_acc, 100);
    end
    for (int i = 1; i <= 4; i++) drv(1, i, i, 0, 1, 1);
    chk("resume_acc", out_acc, 10); chk("resume_max", out_max, 4);
    // reset mid-block discards partial data
    drv(1, 50, 50, 0, 1, 1);
    drv(1, 50, 50, 0, 1, 1);
    drv(1, 50, 50, 0, 1, 0);
    for (int i = 0; i < 4; i++) drv(1, 1, 1, 0, 1, 1);
    chk("rst_mid_acc", out_acc, 4); chk("rst_mid_beats", out_beats, 4);
    // randomized traffic with occasional resets
    for (int n = 0; n < 500; n++)
      drv($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 59) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
